// File: rtl/sfq_xort_word_collector.sv
// Collects the toggle-encoded XOR-T output stream into WIDTH-bit words.
// Each word carries its ones-count and parity and is offered on a valid/ready handshake.
module sfq_xort_word_collector #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 16,
  localparam int OW       = $clog2(WIDTH + 1),
  localparam int BW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  output logic [WIDTH-1:0] word_out,
  output logic [OW-1:0]    ones_out,
  output logic             parity_out,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  output logic [CNT_W-1:0] frame_cnt
);

  logic             din_q;
  logic             pulse_bit;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [BW-1:0]    bit_cnt_reg;
  logic [OW-1:0]    ones_acc_reg;
  logic [OW-1:0]    ones_next;
  logic             last_slot;
  logic             accept;

  // din_q tracks din even during reset, so releasing reset never produces a pulse.
  always_ff @(posedge clk) begin
    din_q <= din;
  end

  assign pulse_bit = din ^ din_q;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign shift_next = {pulse_bit, shift_reg[WIDTH-1:1]};
    end else begin : g_msb_first
      assign shift_next = {shift_reg[WIDTH-2:0], pulse_bit};
    end
  endgenerate

  assign ones_next = ones_acc_reg + OW'(pulse_bit);
  assign last_slot = en && (bit_cnt_reg == BW'(WIDTH - 1));
  // The buffer can take a new word when empty or when it is being drained this cycle.
  assign accept    = last_slot && (!valid || ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      ones_acc_reg <= '0;
      word_out     <= '0;
      ones_out     <= '0;
      parity_out   <= 1'b0;
      valid        <= 1'b0;
      overrun      <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      if (en) begin
        shift_reg <= shift_next;
        if (last_slot) begin
          bit_cnt_reg  <= '0;
          ones_acc_reg <= '0;
        end else begin
          bit_cnt_reg  <= bit_cnt_reg + 1'b1;
          ones_acc_reg <= ones_next;
        end
      end

      if (accept) begin
        word_out   <= shift_next;
        ones_out   <= ones_next;
        parity_out <= ones_next[0];
        valid      <= 1'b1;
        frame_cnt  <= frame_cnt + 1'b1;
      end else if (last_slot) begin
        overrun <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sfq_xort_word_collector.sv
// Scoreboard bench: two collectors (LSB-first and MSB-first) share one random stimulus
// stream and are checked against a bit-queue reference model.
module tb_sfq_xort_word_collector;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic en = 1'b0;
  logic ready = 1'b0;

  logic [W-1:0] l_word, m_word;
  logic [3:0]   l_ones, m_ones;
  logic         l_par, m_par, l_valid, m_valid, l_ovr, m_ovr;
  logic [15:0]  l_cnt, m_cnt;

  sfq_xort_word_collector #(.WIDTH(W), .LSB_FIRST(1'b1), .CNT_W(16)) dut_l (
    .clk(clk), .rst(rst), .din(din), .en(en), .word_out(l_word), .ones_out(l_ones),
    .parity_out(l_par), .valid(l_valid), .ready(ready), .overrun(l_ovr), .frame_cnt(l_cnt));

  sfq_xort_word_collector #(.WIDTH(W), .LSB_FIRST(1'b0), .CNT_W(16)) dut_m (
    .clk(clk), .rst(rst), .din(din), .en(en), .word_out(m_word), .ones_out(m_ones),
    .parity_out(m_par), .valid(m_valid), .ready(ready), .overrun(m_ovr), .frame_cnt(m_cnt));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [W-1:0] wl;
    logic [W-1:0] wm;
  } exp_t;
  exp_t expq[$];

  bit mprev = 1'b0;
  bit mvalid = 1'b0;
  bit movr = 1'b0;
  int mcnt = 0;
  bit bits[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a slot's bit is whether din differs from the previous cycle.
  always @(posedge clk) begin : model
    bit b;
    bit done;
    exp_t e;
    b = din ^ mprev;
    mprev = din;
    done = 1'b0;
    if (rst) begin
      bits.delete();
      expq.delete();
      mvalid = 1'b0;
      movr = 1'b0;
      mcnt = 0;
    end else begin
      if (en) begin
        bits.push_back(b);
        if (bits.size() == W) begin
          for (int i = 0; i < W; i++) begin
            e.wl[i] = bits[i];
            e.wm[W-1-i] = bits[i];
          end
          bits.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (!mvalid || ready) begin
          expq.push_back(e);
          mvalid = 1'b1;
          mcnt = (mcnt + 1) % 65536;
        end else begin
          movr = 1'b1;
        end
      end else if (mvalid && ready) begin
        mvalid = 1'b0;
      end
    end
  end

  // Monitor: status every cycle, word contents on each handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    chk("valid_l", 32'(l_valid), 32'(mvalid));
    chk("valid_m", 32'(m_valid), 32'(mvalid));
    chk("overrun", 32'(l_ovr), 32'(movr));
    chk("overrun_m", 32'(m_ovr), 32'(movr));
    chk("frame_cnt", 32'(l_cnt), 32'(mcnt));
    chk("frame_cnt_m", 32'(m_cnt), 32'(mcnt));
    if (l_valid && ready && !rst) begin
      if (expq.size() == 0) begin
        chk("pop_nonempty", 32'(expq.size()), 32'd1);
      end else begin
        e = expq.pop_front();
        chk("word_l", 32'(l_word), 32'(e.wl));
        chk("word_m", 32'(m_word), 32'(e.wm));
        chk("ones_l", 32'(l_ones), 32'($countones(e.wl)));
        chk("ones_m", 32'(m_ones), 32'($countones(e.wm)));
        chk("parity_l", 32'(l_par), 32'(^e.wl));
        chk("parity_m", 32'(m_par), 32'(^e.wm));
        $display("word lsb=%02h msb=%02h ones=%0d cnt=%0d", l_word, m_word, l_ones, l_cnt);
      end
    end
  end

  task automatic cyc(input bit tog, input bit e, input bit r);
    din = din ^ tog;
    en = e;
    ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit r, input bit r_last);
    for (int i = 0; i < W; i++) cyc(w[i], 1'b1, (i == W - 1) ? r_last : r);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    // Reset with din high from the start: no pulse may appear after release.
    din = 1'b1;
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("reset_valid", 32'(l_valid), 32'd0);
    chk("reset_cnt", 32'(l_cnt), 32'd0);
    for (int i = 0; i < W; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("quiet_word", 32'(l_word), 32'h00);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b1);

    // Basic word.
    do_reset();
    send_word(8'h8D, 1'b1, 1'b1);
    chk("basic_word_l", 32'(l_word), 32'h8D);
    chk("basic_word_m", 32'(m_word), 32'hB1);
    chk("basic_ones", 32'(l_ones), 32'd4);
    chk("basic_parity", 32'(l_par), 32'd0);
    chk("basic_cnt", 32'(l_cnt), 32'd1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("basic_drop", 32'(l_valid), 32'd0);

    // Enable gaps with din toggling inside them.
    do_reset();
    cyc(1'b1, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b1); cyc(1'b1, 1'b1, 1'b1); cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b1); cyc(1'b1, 1'b1, 1'b1);
    chk("gap_word_m", 32'(m_word), 32'hB1);
    chk("gap_ones_m", 32'(m_ones), 32'd4);

    // Backpressure and overrun.
    do_reset();
    send_word(8'hFF, 1'b0, 1'b0);
    send_word(8'h01, 1'b0, 1'b0);
    chk("bp_word", 32'(l_word), 32'hFF);
    chk("bp_ones", 32'(l_ones), 32'd8);
    chk("bp_parity", 32'(l_par), 32'd0);
    chk("bp_overrun", 32'(l_ovr), 32'd1);
    chk("bp_cnt", 32'(l_cnt), 32'd1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("bp_drain_valid", 32'(l_valid), 32'd0);
    chk("bp_sticky", 32'(l_ovr), 32'd1);

    // Back-to-back: drain coincides with completion.
    do_reset();
    send_word(8'hFF, 1'b0, 1'b0);
    send_word(8'h01, 1'b0, 1'b1);
    chk("b2b_valid", 32'(l_valid), 32'd1);
    chk("b2b_word_l", 32'(l_word), 32'h01);
    chk("b2b_word_m", 32'(m_word), 32'h80);
    chk("b2b_parity", 32'(l_par), 32'd1);
    chk("b2b_cnt", 32'(l_cnt), 32'd2);
    chk("b2b_overrun", 32'(l_ovr), 32'd0);
    cyc(1'b0, 1'b0, 1'b1);

    // Reset in the middle of a word.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1);
    do_reset();
    send_word(8'h0F, 1'b1, 1'b1);
    chk("midrst_word", 32'(l_word), 32'h0F);
    chk("midrst_cnt", 32'(l_cnt), 32'd1);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
    end

    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);
    chk("queue_empty", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sfq_xort_word_collector.md
Name: sfq_xort_word_collector

Overview:
- Downstream stage of the clocked XOR-T cell. It consumes the cell's `out` pulse stream, which uses the toggle encoding of the cell models: each transition of the signal is one SFQ pulse.
- It converts pulse/no-pulse per clock window into bits, deserialises them into WIDTH-bit words, and computes ones-count and parity per word.
- It presents each word on a valid/ready handshake to the checker/scoreboard logic.
- `din` is synchronous to `clk` and changes at most once per `clk` cycle.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- LSB_FIRST, 1: 1 = first received bit lands in word_out[0]; 0 = first bit lands in word_out[WIDTH-1].
- CNT_W, 16: width of frame_cnt.

Ports:
- clk  input  1  system clock; one clock window = one bit slot.
- rst  input  1  synchronous, active-high reset.
- din  input  1  toggle-encoded pulse stream from the XOR-T `out`.
- en  input  1  bit-slot enable; when low the slot is ignored (no shift, no count).
- word_out  output  WIDTH  completed word.
- ones_out  output  $clog2(WIDTH+1)  number of 1 bits in word_out.
- parity_out  output  1  XOR of all bits of word_out.
- valid  output  1  word_out/ones_out/parity_out are valid.
- ready  input  1  consumer accepts the word when valid && ready.
- overrun  output  1  sticky: a completed word was dropped.
- frame_cnt  output  CNT_W  number of words accepted into the output buffer; wraps modulo 2^CNT_W.

Behaviour:
- Pulse detect:
  - din_q <= din every cycle, including during rst, so no spurious pulse follows reset.
  - bit = din ^ din_q. A transition in cycle N yields bit=1 for slot N.
- Reset (rst=1 at a clk edge):
  - shift register, bit counter, word_out, ones_out, parity_out, valid, overrun and frame_cnt all go to 0.
  - A partially assembled word is discarded.
  - rst has priority over every other event.
- Assembly (en=1):
  - Shift in `bit` (LSB_FIRST selects direction).
  - Increment bit_cnt over 0..WIDTH-1.
  - Running ones/parity accumulators update in the same cycle.
  - en=0 freezes shift register, bit_cnt and accumulators.
- Word completion is the cycle with en=1 and bit_cnt==WIDTH-1. The assembled word includes that cycle's bit.
  - If the output buffer is free (valid==0) or drains this cycle (valid && ready), then on the next edge:
    - load word_out, ones_out, parity_out;
    - set valid=1;
    - frame_cnt+1.
  - Otherwise the word is dropped: overrun<=1 (sticky until rst), frame_cnt unchanged, buffer contents unchanged.
  - In both cases bit_cnt and accumulators restart at 0. The next slot begins a new word with no gap.
- Handshake:
  - valid stays high, and outputs stay stable, until a cycle with ready=1.
  - Drain without a simultaneous completion: valid <= 0 on the next edge.
  - Drain with a simultaneous completion: back-to-back, valid stays 1 and new data is loaded.
  - Throughput is one word per WIDTH enabled cycles.
  - ready while valid=0 has no effect.
- Latency: from the clk edge sampling the last bit's transition to valid=1 is 1 cycle (registered outputs).
- Arithmetic:
  - ones_out ranges 0..WIDTH.
  - parity_out = ones_out[0].
  - frame_cnt wraps from 2^CNT_W-1 to 0 without a flag.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset and no spurious pulse: din=1 held through rst, rst released, din held → valid stays 0 for 20 cycles, frame_cnt=0, overrun=0.
- Basic word: WIDTH=8, LSB_FIRST=1, en=1, bit slots 1,0,1,1,0,0,0,1 (a din toggle in each 1-slot), ready=1 → one cycle after slot 8: word_out=8'h8D, ones_out=4, parity_out=0, valid=1 for one cycle, frame_cnt=1.
- MSB-first and en gaps: LSB_FIRST=0, same bit sequence with en=0 for 3 cycles after slot 4 (din toggles in those cycles ignored) → word_out=8'hB1, ones_out=4.
- Backpressure / overrun: ready=0, two consecutive 8-bit words 8'hFF then 8'h01 → first word held (word_out=8'hFF, ones_out=8, parity_out=0), second dropped, overrun=1, frame_cnt=1. Then ready=1 → valid drops next cycle, overrun stays 1.
- Back-to-back: ready=1 pulsed in exactly the cycle the second word completes → valid stays 1, word_out changes 8'hFF→8'h01, parity_out=1, frame_cnt=2, overrun=0.
- Reset mid-word: 5 bits shifted, rst one cycle, then a full word 8'h0F → word_out=8'h0F with no residue of the aborted bits, frame_cnt=1.
